frame_loader: RTL
=================

# frame_loader

Upstream feeder for `display_controller`. Accepts a byte stream from the host link (UART/SPI receiver) through a valid/ready handshake and unpacks two 12-bit RGB444 pixels from every three bytes. Issues one `w_en` write per pixel on the controller's framebuffer write port, addressing pixels linearly 0..4095. Frames are delimited by a sync byte and guarded by an inter-byte timeout.

## Interface
- `SYNC_BYTE`, 8'hA5: byte that starts a frame when received in IDLE.
- `TIMEOUT_CYCLES`, 100000: maximum idle cycles between accepted bytes while in LOAD; must be less than 2^24.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_data` in 8: host byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: a byte is accepted on any edge where `in_valid & in_ready` is high.
- `write_addr` out 12: pixel address; bit 11 selects the bottom half. Drives `display_controller.write_addr`.
- `w_en` out 1: write strobe, one cycle per pixel.
- `pixel_out` out 12: pixel; [3:0] red, [7:4] green, [11:8] blue.
- `busy` out 1: high in LOAD and during a pending write.
- `frame_done` out 1: one-cycle pulse on the write of pixel 4095.
- `error` out 1: one-cycle pulse on timeout abort.

## Operation
- States: IDLE, LOAD.
- IDLE:
  - `in_ready`=1.
  - Non-sync bytes are accepted and dropped.
  - `SYNC_BYTE` moves the block to LOAD; pixel counter=0, byte phase=0, timeout counter=0.
- LOAD byte phases, cycling 0, 1, 2:
  - b0 → A[7:0].
  - b1 → A[11:8]=b1[3:0], B[3:0]=b1[7:4].
  - b2 → B[11:4]=b2.
- Accepting b2 schedules two writes: pixel A at address 2k, then pixel B at address 2k+1, where k is the triple index (0..2047).
- Inside LOAD, a byte equal to `SYNC_BYTE` is ordinary data. There is no escaping.
- Timeout counter:
  - Increments on every LOAD cycle without an accepted byte.
  - Clears on every accepted byte.
  - On reaching `TIMEOUT_CYCLES`: `error` pulses, state becomes IDLE, partial bytes are discarded, and pixels already written are left in place.
- After pixel 4095 is written, `frame_done` pulses and the state returns to IDLE.
- Pixel address arithmetic is 12-bit. It never wraps within a frame because the frame ends at 4095.

## Timing
- Reset values (one edge after `rst` is high): state IDLE, `in_ready`=1, `w_en`=0, `write_addr`=0, `pixel_out`=0, `busy`=0, `frame_done`=0, `error`=0, all counters 0.
- `rst` asserted mid-frame:
  - A pending pixel-B write is cancelled.
  - `w_en` is 0 on the next cycle.
  - No `frame_done` and no `error` are generated.
- All outputs are registered.
- For b2 accepted at edge t:
  - Cycle t+1: `w_en`=1, `write_addr`=2k, `pixel_out`=A, `in_ready`=0.
  - Cycle t+2: `w_en`=1, `write_addr`=2k+1, `pixel_out`=B, `in_ready`=1.
- A byte accepted at t+2 is the next b0 and is legal. The maximum sustained rate is therefore 3 bytes per 4 cycles.
- `frame_done` is high in the same cycle as the `w_en` for address 4095. The state is IDLE, `busy`=0 and `in_ready`=1 in the following cycle.
- `w_en` is 0 in every cycle not listed above.
- `busy` goes high the cycle after the sync byte is accepted.
- `error` and the transition to IDLE occur the cycle after the timeout counter reaches `TIMEOUT_CYCLES`.
- `in_valid` without `in_ready` does not consume the byte. The upstream source must hold `in_data`.

## Test plan
- Reset, then send A5, 34, C2, AB → writes at addr 0 with pixel 0x234 and addr 1 with pixel 0xABC on consecutive cycles. `in_ready`=0 only during the first write cycle.
- Send garbage bytes 00, FF, 12, then A5, then a full 6144-byte frame at the maximum rate → exactly 4096 `w_en` pulses at addresses 0..4095 in order, one `frame_done` coincident with address 4095, and no writes from the garbage bytes.
- Send A5 and 10 bytes, then idle for `TIMEOUT_CYCLES` (set to 50) → `error` pulses once, no further `w_en`. A following A5 restarts addressing at 0.
- Send a frame whose data contains A5 bytes → treated as pixel data, address sequence unbroken.
- Assert `rst` in the cycle between the two writes of a pair → no pixel-B write, all outputs at their reset values, next frame starts at address 0.
- Hold `in_valid` high continuously with back-to-back bytes → no byte is lost or duplicated across the `in_ready`=0 cycles. Checked against a reference model over 3 frames.

Source files
------------

// File: rtl/frame_loader.sv
// -----------------------------------------------------------------------------
// frame_loader
//
// Purpose:
//   Host-side feeder for the display_controller framebuffer write port. Takes
//   a byte stream on a valid/ready handshake and unpacks two 12-bit RGB444
//   pixels from every three bytes. Each pixel becomes one single-cycle write
//   at a linear address 0..4095.
//
//   A frame starts with SYNC_BYTE received while idle. It ends either after
//   pixel 4095 is written (frame_done pulse) or when the link goes quiet for
//   TIMEOUT_CYCLES while loading (error pulse). On a timeout, pixels that were
//   already written stay in the framebuffer.
//
// Parameters:
//   SYNC_BYTE       byte that opens a frame when seen in IDLE
//   TIMEOUT_CYCLES  max idle cycles between accepted bytes in LOAD (< 2^24)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high
//   in_data     in   [7:0] host byte
//   in_valid    in   in_data is valid
//   in_ready    out  byte accepted on an edge where in_valid & in_ready
//   write_addr  out  [11:0] pixel address (bit 11 = bottom half)
//   w_en        out  write strobe, one cycle per pixel
//   pixel_out   out  [11:0] pixel, [3:0] R, [7:4] G, [11:8] B
//   busy        out  high while loading or while a write is pending
//   frame_done  out  one-cycle pulse together with the write of pixel 4095
//   error       out  one-cycle pulse on timeout abort
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module frame_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] write_addr,
  output logic        w_en,
  output logic [11:0] pixel_out,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam logic [23:0] TIMEOUT_LIMIT = 24'(TIMEOUT_CYCLES);
  // Address of pixel A in the final pair. Its pixel B is address 4095.
  localparam logic [11:0] LAST_PAIR_BASE = 12'd4094;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD
  } state_t;

  state_t      r_state;
  logic [1:0]  r_phase;      // byte position inside the current triple
  logic [11:0] r_pix_addr;   // address of pixel A of the triple being built
  logic [11:0] r_pix_a;      // pixel A as it is assembled from b0/b1
  logic [3:0]  r_b_lo;       // low nibble of pixel B, carried in b1[7:4]
  logic [11:0] r_pix_b;      // complete pixel B, waiting for its write slot
  logic        r_b_pending;  // pixel B must be written on the next edge
  logic [23:0] r_tcnt;       // idle cycles since the last accepted byte

  logic        w_accept;

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= 2'd0;
      r_pix_addr  <= 12'd0;
      r_pix_a     <= 12'd0;
      r_b_lo      <= 4'd0;
      r_pix_b     <= 12'd0;
      r_b_pending <= 1'b0;
      r_tcnt      <= 24'd0;
      in_ready    <= 1'b1;
      write_addr  <= 12'd0;
      w_en        <= 1'b0;
      pixel_out   <= 12'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      // Strobes default low; only the branches below raise them.
      w_en       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;

      if (r_b_pending) begin
        // Second write of a pair. in_ready was low during this cycle, so no
        // byte can be accepted here and the pending write cannot collide
        // with byte handling.
        r_b_pending <= 1'b0;
        w_en        <= 1'b1;
        write_addr  <= r_pix_addr + 12'd1;
        pixel_out   <= r_pix_b;
        in_ready    <= 1'b1;
        busy        <= 1'b1;
        r_pix_addr  <= r_pix_addr + 12'd2;
        r_tcnt      <= r_tcnt + 24'd1;
        if (r_pix_addr == LAST_PAIR_BASE) begin
          // Frame complete. The machine goes idle now, so a byte accepted
          // during this final write cycle is already treated as an
          // idle-state byte (for example, the next frame's sync).
          frame_done <= 1'b1;
          r_state    <= ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            if (w_accept && (in_data == SYNC_BYTE)) begin
              r_state    <= ST_LOAD;
              busy       <= 1'b1;
              r_pix_addr <= 12'd0;
              r_phase    <= 2'd0;
              r_tcnt     <= 24'd0;
            end
          end

          ST_LOAD: begin
            busy     <= 1'b1;
            in_ready <= 1'b1;
            if (r_tcnt == TIMEOUT_LIMIT) begin
              // Abort. A byte offered in this same cycle loses to the abort
              // and is dropped. Any partial triple is discarded because the
              // next sync resets the phase.
              error   <= 1'b1;
              r_state <= ST_IDLE;
              busy    <= 1'b0;
              r_phase <= 2'd0;
            end else if (w_accept) begin
              r_tcnt <= 24'd0;
              case (r_phase)
                2'd0: begin
                  r_pix_a[7:0] <= in_data;
                  r_phase      <= 2'd1;
                end
                2'd1: begin
                  r_pix_a[11:8] <= in_data[3:0];
                  r_b_lo        <= in_data[7:4];
                  r_phase       <= 2'd2;
                end
                2'd2: begin
                  // Pixel A goes out now. Pixel B follows on the next edge.
                  // in_ready drops for one cycle to leave room for it.
                  w_en        <= 1'b1;
                  write_addr  <= r_pix_addr;
                  pixel_out   <= r_pix_a;
                  r_pix_b     <= {in_data, r_b_lo};
                  r_b_pending <= 1'b1;
                  in_ready    <= 1'b0;
                  r_phase     <= 2'd0;
                end
                default: begin
                  r_phase <= 2'd0;
                end
              endcase
            end else begin
              r_tcnt <= r_tcnt + 24'd1;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
